// File: rtl/tmc_init_sequencer.sv
// Power-up configuration sequencer for a chain of TMC2130 drivers on one SPI master.
// Walks the external register table once per chip select and checks SPI_STATUS per datagram.
module tmc_init_sequencer #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned NUM_REGS = 6,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            r_state_clk,
  input  logic            reset_n_in,
  input  logic            start_in,
  output logic [IDX_W-1:0] tbl_idx_out,
  input  logic [39:0]     tbl_data_in,
  output logic [39:0]     spi_data_out,
  output logic [CH_W-1:0] spi_cs_sel_out,
  output logic            spi_send_en_out,
  input  logic            spi_done_in,
  input  logic [39:0]     spi_data_in,
  output logic            busy_out,
  output logic            done_out,
  output logic            error_out,
  output logic [CH_W-1:0] err_ch_out,
  output logic [1:0]      err_code_out,
  output logic [7:0]      status_out
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_CHECK,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [39:0]      spi_data_q, spi_data_d;
  logic [CH_W-1:0]  cs_sel_q, cs_sel_d;
  logic             send_en_q, send_en_d;
  logic [7:0]       status_q, status_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CH_W-1:0]  err_ch_q, err_ch_d;
  logic [1:0]       err_code_q, err_code_d;

  always_ff @(posedge r_state_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ch_q       <= '0;
      tmo_q      <= '0;
      spi_data_q <= '0;
      cs_sel_q   <= '0;
      send_en_q  <= 1'b0;
      status_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_ch_q   <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ch_q       <= ch_d;
      tmo_q      <= tmo_d;
      spi_data_q <= spi_data_d;
      cs_sel_q   <= cs_sel_d;
      send_en_q  <= send_en_d;
      status_q   <= status_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_ch_q   <= err_ch_d;
      err_code_q <= err_code_d;
    end
  end

  // Flags are set on the transition into DONE/ERROR so they are visible in those states.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ch_d       = ch_q;
    tmo_d      = tmo_q;
    spi_data_d = spi_data_q;
    cs_sel_d   = cs_sel_q;
    send_en_d  = 1'b0;
    status_d   = status_q;
    done_d     = done_q;
    error_d    = error_q;
    err_ch_d   = err_ch_q;
    err_code_d = err_code_q;
    tmo_inc    = tmo_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          idx_d      = '0;
          ch_d       = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'b00;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        spi_data_d = tbl_data_in;
        cs_sel_d   = ch_q;
        send_en_d  = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the same cycle the budget runs out still counts.
        if (spi_done_in) begin
          status_d = spi_data_in[39:32];
          state_d  = ST_CHECK;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) begin
            err_code_d = 2'b10;
            error_d    = 1'b1;
            err_ch_d   = ch_q;
            state_d    = ST_ERROR;
          end
        end
      end
      ST_CHECK: begin
        if (status_q[1]) begin
          err_code_d = 2'b01;
          error_d    = 1'b1;
          err_ch_d   = ch_q;
          state_d    = ST_ERROR;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q < IDX_LAST) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end else begin
          idx_d = '0;
          if (ch_q < CH_LAST) begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign tbl_idx_out     = idx_q;
  assign spi_data_out    = spi_data_q;
  assign spi_cs_sel_out  = cs_sel_q;
  assign spi_send_en_out = send_en_q;
  assign status_out      = status_q;
  assign done_out        = done_q;
  assign error_out       = error_q;
  assign err_ch_out      = err_ch_q;
  assign err_code_out    = err_code_q;
  assign busy_out        = (state_q == ST_LOAD) || (state_q == ST_SEND) ||
                           (state_q == ST_WAIT) || (state_q == ST_CHECK) ||
                           (state_q == ST_NEXT);

endmodule

// File: tb/tb_tmc_init_sequencer.sv
// Bench for tmc_init_sequencer: scenario table, hand-written corner sequences and
// randomized transfer plans checked against a transfer-level reference model.
module tb_tmc_init_sequencer;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned TMO      = 16;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned CH_W     = 1;
  localparam int NXF = NUM_CH * NUM_REGS;

  localparam logic [39:0] ROM [NUM_REGS] = '{
    40'hEC000100C3, 40'h9000061F0A, 40'h910000000A,
    40'h8000000004, 40'h93000001F4, 40'hF0000401C8
  };

  logic             r_state_clk;
  logic             reset_n_in;
  logic             start_in;
  logic [IDX_W-1:0] tbl_idx_out;
  logic [39:0]      tbl_data_in;
  logic [39:0]      spi_data_out;
  logic [CH_W-1:0]  spi_cs_sel_out;
  logic             spi_send_en_out;
  logic             spi_done_in;
  logic [39:0]      spi_data_in;
  logic             busy_out;
  logic             done_out;
  logic             error_out;
  logic [CH_W-1:0]  err_ch_out;
  logic [1:0]       err_code_out;
  logic [7:0]       status_out;

  tmc_init_sequencer #(
    .NUM_CH   (NUM_CH),
    .NUM_REGS (NUM_REGS),
    .TIMEOUT  (TMO),
    .IDX_W    (IDX_W),
    .CH_W     (CH_W)
  ) dut (
    .r_state_clk     (r_state_clk),
    .reset_n_in      (reset_n_in),
    .start_in        (start_in),
    .tbl_idx_out     (tbl_idx_out),
    .tbl_data_in     (tbl_data_in),
    .spi_data_out    (spi_data_out),
    .spi_cs_sel_out  (spi_cs_sel_out),
    .spi_send_en_out (spi_send_en_out),
    .spi_done_in     (spi_done_in),
    .spi_data_in     (spi_data_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out),
    .err_ch_out      (err_ch_out),
    .err_code_out    (err_code_out),
    .status_out      (status_out)
  );

  assign tbl_data_in = (int'(tbl_idx_out) < NUM_REGS) ? ROM[int'(tbl_idx_out)] : 40'h0;

  initial begin
    r_state_clk = 1'b0;
    forever #5 r_state_clk = ~r_state_clk;
  end

  int cyc = 0;
  always @(posedge r_state_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Per-transfer responder plan: completion delay (cycles after the send pulse) and status.
  int         plan_k  [NXF];
  logic [7:0] plan_st [NXF];

  typedef struct {
    int               cyc;
    logic [39:0]      data;
    logic [CH_W-1:0]  cs;
    logic [IDX_W-1:0] idx;
    logic             busy;
  } snd_t;

  snd_t sends[$];
  int   done_rise = -1;
  int   err_rise  = -1;

  // Observed send pulses and flag rise times.
  initial begin
    logic prev_done, prev_err;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge r_state_clk);
      if (spi_send_en_out)
        sends.push_back('{cyc, spi_data_out, spi_cs_sel_out, tbl_idx_out, busy_out});
      if (done_out && !prev_done && done_rise < 0) done_rise = cyc;
      if (error_out && !prev_err && err_rise < 0) err_rise = cyc;
      prev_done = done_out;
      prev_err  = error_out;
    end
  end

  // SPI slave: answers each send after plan_k cycles with plan_st in the status byte.
  initial begin
    int t, k;
    spi_done_in = 1'b0;
    spi_data_in = '0;
    forever begin
      @(negedge r_state_clk);
      if (spi_send_en_out && reset_n_in) begin
        t = int'(spi_cs_sel_out) * NUM_REGS + int'(tbl_idx_out);
        if (t >= NXF) t = 0;
        k = plan_k[t];
        repeat (k) @(negedge r_state_clk);
        spi_done_in = 1'b1;
        spi_data_in = {plan_st[t], 32'($urandom)};
        @(negedge r_state_clk);
        spi_done_in = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: transfer-level outcome of the current plan.
  typedef struct {
    int               rel;
    logic [39:0]      data;
    logic [CH_W-1:0]  cs;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_status = 8'h00;
  bit         m_done, m_err;
  logic [1:0] m_code;
  logic [CH_W-1:0] m_ch;
  int         m_end;

  task automatic model_plan();
    int rel;
    logic [7:0] st;
    rel = 2;
    st = model_status;
    m_done = 0; m_err = 0; m_code = 2'b00; m_ch = '0; m_end = -1;
    exp_q.delete();
    for (int t = 0; t < NXF; t++) begin
      exp_q.push_back('{rel, ROM[t % NUM_REGS], CH_W'(t / NUM_REGS), IDX_W'(t % NUM_REGS)});
      if (plan_k[t] > int'(TMO)) begin
        m_err = 1; m_code = 2'b10; m_ch = CH_W'(t / NUM_REGS); m_end = rel + int'(TMO) + 1;
        break;
      end
      st = plan_st[t];
      if (st[1]) begin
        m_err = 1; m_code = 2'b01; m_ch = CH_W'(t / NUM_REGS); m_end = rel + plan_k[t] + 2;
        break;
      end
      if (t == NXF - 1) begin
        m_done = 1; m_end = rel + plan_k[t] + 3;
      end
      rel += plan_k[t] + 4;
    end
    model_status = st;
  endtask

  task automatic do_run(input string tag, input bit poke);
    int start_c, n;
    bit to;
    model_plan();
    @(negedge r_state_clk);
    sends.delete();
    done_rise = -1;
    err_rise  = -1;
    start_c   = cyc;
    start_in  = 1'b1;
    @(negedge r_state_clk);
    start_in = 1'b0;
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!busy_out) begin to = 0; break; end
      @(negedge r_state_clk);
      if (poke && i == 20) start_in = 1'b1;
      if (poke && i == 21) start_in = 1'b0;
    end
    start_in = 1'b0;
    if (to) begin
      bad++; total++;
      $display("FAIL %s_busy_timeout: got busy=1 expected busy=0 within 3000 cycles", tag);
    end
    repeat (30) @(negedge r_state_clk);
    chk({tag, "_n_sends"}, sends.size(), exp_q.size());
    n = (sends.size() < exp_q.size()) ? sends.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), sends[i].data, exp_q[i].data);
      chk($sformatf("%s_cs%0d", tag, i), sends[i].cs, exp_q[i].cs);
      chk($sformatf("%s_idx%0d", tag, i), sends[i].idx, exp_q[i].idx);
      chk($sformatf("%s_cyc%0d", tag, i), sends[i].cyc - start_c, exp_q[i].rel);
      chk($sformatf("%s_busy%0d", tag, i), sends[i].busy, 1'b1);
    end
    chk({tag, "_done"}, done_out, m_done);
    chk({tag, "_error"}, error_out, m_err);
    chk({tag, "_status"}, status_out, model_status);
    chk({tag, "_busy_end"}, busy_out, 1'b0);
    if (m_err) begin
      chk({tag, "_code"}, err_code_out, m_code);
      chk({tag, "_err_ch"}, err_ch_out, m_ch);
      chk({tag, "_err_cyc"}, err_rise - start_c, m_end);
    end else begin
      chk({tag, "_code"}, err_code_out, 2'b00);
      chk({tag, "_done_cyc"}, done_rise - start_c, m_end);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_send"}, spi_send_en_out, 1'b0);
    chk({tag, "_busy"}, busy_out, 1'b0);
    chk({tag, "_done"}, done_out, 1'b0);
    chk({tag, "_error"}, error_out, 1'b0);
    chk({tag, "_data"}, spi_data_out, 40'h0);
    chk({tag, "_cs"}, spi_cs_sel_out, '0);
    chk({tag, "_idx"}, tbl_idx_out, '0);
    chk({tag, "_status"}, status_out, 8'h00);
    chk({tag, "_code"}, err_code_out, 2'b00);
    chk({tag, "_err_ch"}, err_ch_out, '0);
  endtask

  task automatic plan_fill(input int k, input logic [7:0] st);
    for (int t = 0; t < NXF; t++) begin
      plan_k[t]  = k;
      plan_st[t] = st;
    end
  endtask

  typedef struct {
    int          fx;
    int          fk;
    logic [7:0]  fst;
    int          dk;
    bit          e_done;
    bit          e_err;
    logic [1:0]  e_code;
    logic [0:0]  e_ch;
    int          e_sends;
    logic [7:0]  e_status;
  } vec_t;

  vec_t vec [9];

  initial begin
    int n;
    bit to;
    vec[0] = '{-1,  5, 8'h00, 5, 1'b1, 1'b0, 2'b00, 1'b0, 12, 8'h00};
    vec[1] = '{ 9,  5, 8'h02, 5, 1'b0, 1'b1, 2'b01, 1'b1, 10, 8'h02};
    vec[2] = '{ 2, 20, 8'h00, 5, 1'b0, 1'b1, 2'b10, 1'b0,  3, 8'h00};
    vec[3] = '{ 7, 16, 8'h00, 5, 1'b1, 1'b0, 2'b00, 1'b0, 12, 8'h00};
    vec[4] = '{11,  3, 8'h01, 5, 1'b1, 1'b0, 2'b00, 1'b0, 12, 8'h01};
    vec[5] = '{ 6, 17, 8'h00, 5, 1'b0, 1'b1, 2'b10, 1'b1,  7, 8'h00};
    vec[6] = '{11,  1, 8'h03, 5, 1'b0, 1'b1, 2'b01, 1'b1, 12, 8'h03};
    vec[7] = '{ 0,  2, 8'hFE, 5, 1'b0, 1'b1, 2'b01, 1'b0,  1, 8'hFE};
    vec[8] = '{ 5,  1, 8'h00, 1, 1'b1, 1'b0, 2'b00, 1'b0, 12, 8'h00};

    start_in   = 1'b0;
    reset_n_in = 1'b0;
    plan_fill(5, 8'h00);
    repeat (3) @(negedge r_state_clk);
    check_all_zero("in_reset");
    reset_n_in = 1'b1;
    sends.delete();
    repeat (20) @(negedge r_state_clk);
    check_all_zero("idle");
    chk("idle_no_send", sends.size(), 0);

    for (int v = 0; v < 9; v++) begin
      plan_fill(vec[v].dk, 8'h00);
      if (vec[v].fx >= 0) begin
        plan_k[vec[v].fx]  = vec[v].fk;
        plan_st[vec[v].fx] = vec[v].fst;
      end
      do_run($sformatf("vec%0d", v), 1'b0);
      chk($sformatf("vec%0d_tbl_sends", v), sends.size(), vec[v].e_sends);
      chk($sformatf("vec%0d_tbl_done", v), done_out, vec[v].e_done);
      chk($sformatf("vec%0d_tbl_err", v), error_out, vec[v].e_err);
      chk($sformatf("vec%0d_tbl_status", v), status_out, vec[v].e_status);
      if (vec[v].e_err) begin
        chk($sformatf("vec%0d_tbl_code", v), err_code_out, vec[v].e_code);
        chk($sformatf("vec%0d_tbl_ch", v), err_ch_out, vec[v].e_ch);
      end
    end

    // Start pulse while busy must not disturb the running sequence.
    plan_fill(5, 8'h00);
    do_run("poke", 1'b1);

    // Held start: the sequence restarts from ch0 idx0 as soon as IDLE is re-entered.
    plan_fill(5, 8'h00);
    @(negedge r_state_clk);
    sends.delete();
    start_in = 1'b1;
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge r_state_clk);
      if (sends.size() >= 13) begin to = 0; break; end
    end
    start_in = 1'b0;
    chk("hold_restart_seen", to, 1'b0);
    if (!to) begin
      chk("hold_gap", sends[12].cyc - sends[11].cyc, 11);
      chk("hold_cs", sends[12].cs, '0);
      chk("hold_idx", sends[12].idx, '0);
      chk("hold_data", sends[12].data, ROM[0]);
    end
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      if (!busy_out) begin to = 0; break; end
      @(negedge r_state_clk);
    end
    chk("hold_end_busy", to, 1'b0);
    chk("hold_done", done_out, 1'b1);
    chk("hold_n_sends", sends.size(), 24);
    model_status = 8'h00;

    // Asynchronous reset in the middle of a WAIT on channel 1.
    plan_fill(10, 8'h01);
    @(negedge r_state_clk);
    sends.delete();
    start_in = 1'b1;
    @(negedge r_state_clk);
    start_in = 1'b0;
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      if (sends.size() >= 8) begin to = 0; break; end
      @(negedge r_state_clk);
    end
    chk("rst_reach_ch1", to, 1'b0);
    repeat (3) @(negedge r_state_clk);
    chk("pre_rst_busy", busy_out, 1'b1);
    chk("pre_rst_status", status_out, 8'h01);
    chk("pre_rst_cs", spi_cs_sel_out, 1'b1);
    #1 reset_n_in = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge r_state_clk);
    check_all_zero("rst_next");
    reset_n_in = 1'b1;
    model_status = 8'h00;
    sends.delete();
    repeat (25) @(negedge r_state_clk);
    chk("post_rst_no_send", sends.size(), 0);
    chk("post_rst_busy", busy_out, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int t = 0; t < NXF; t++) begin
        plan_k[t]  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 24))
                                                  : int'($urandom_range(1, 16));
        plan_st[t] = ($urandom_range(0, 24) == 0) ? (8'($urandom) | 8'h02)
                                                  : (8'($urandom) & 8'hFD);
      end
      do_run($sformatf("rnd%0d", r), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
